awmf_beam_word_feeder: RTL

- Upstream stage of the five AWMF-0165 chain groups: on a beam-load command, reads one 256-bit beam frame (8 x 32-bit words) from the beam-code RAM.
- Streams the words into the per-group 32-bit write ports (uN_write_data_en / uN_write_data_in) of the selected groups.
- Replaces per-word CPU writes so a whole beam can be loaded with one command.
- Runs in the write-side (clk) domain of the group write buffers.

---
 rtl/awmf_beam_word_feeder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/awmf_beam_word_feeder.sv
// awmf_beam_word_feeder
// Loads one beam frame (WORDS_PER_FRAME x 32-bit words) from the beam-code RAM
// into the write ports of the selected AWMF-0165 chain groups on a single
// command. Runs in the write-side clock domain of the group write buffers.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   cmd_valid/ready : beam-load handshake; ready only while idle
//   cmd_beam_idx    : beam index, cmd_group_mask : groups to load
//   grp_busy        : per-group busy; gates the start of a frame only
//   ram_rd_en/addr  : beam RAM read strobe and word address {idx, word}
//   ram_rd_data     : RAM data, valid RD_LAT cycles after ram_rd_en
//   wr_en/wr_data   : per-group write enable, broadcast write data
//   done            : one-cycle pulse at the end of every command
//   err_empty_mask  : pulses with done when the command mask was zero
//   frame_cnt       : completed (non-empty) frames, wraps at 16 bits

// One write-enable flop per chain group.
module awmf_wr_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic sel,
    output logic en
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en <= 1'b0;
        else        en <= load & sel;
    end
endmodule

module awmf_beam_word_feeder #(
    parameter int NUM_GROUPS      = 5,
    parameter int WORDS_PER_FRAME = 8,
    parameter int IDX_W           = 7,
    parameter int RD_LAT          = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [IDX_W-1:0]      cmd_beam_idx,
    input  logic [NUM_GROUPS-1:0] cmd_group_mask,
    input  logic [NUM_GROUPS-1:0] grp_busy,
    output logic                  ram_rd_en,
    output logic [IDX_W+2:0]      ram_rd_addr,
    input  logic [31:0]           ram_rd_data,
    output logic [NUM_GROUPS-1:0] wr_en,
    output logic [31:0]           wr_data,
    output logic                  done,
    output logic                  err_empty_mask,
    output logic [15:0]           frame_cnt
);
    localparam int WK_W = 3;
    localparam logic [WK_W-1:0] LAST_WORD = WK_W'(WORDS_PER_FRAME - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_GRP, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic                    rst_done;   // holds cmd_ready low for the first cycle out of reset
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_GROUPS-1:0]   mask_q;
    logic [WK_W-1:0]         word_k;
    logic [RD_LAT:1]         vld_pipe;   // vld_pipe[i]: a read issued i cycles ago
    logic                    accept;

    assign accept      = cmd_valid && cmd_ready;
    assign ram_rd_addr = {idx_q, word_k};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rst_done  <= 1'b0;
            idx_q     <= '0;
            mask_q    <= '0;
            word_k    <= '0;
            vld_pipe  <= '0;
            wr_data   <= '0;
            frame_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
            if (accept) begin
                idx_q  <= cmd_beam_idx;
                mask_q <= cmd_group_mask;
                word_k <= '0;
            end else if (state == S_READ) begin
                word_k <= word_k + 1'b1;
            end
            vld_pipe[1] <= ram_rd_en;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            // wr_data only moves with returned data so it holds between frames
            if (vld_pipe[RD_LAT]) wr_data <= ram_rd_data;
            if (state == S_DONE && mask_q != '0) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        cmd_ready      = 1'b0;
        ram_rd_en      = 1'b0;
        done           = 1'b0;
        err_empty_mask = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = rst_done;
                if (accept) state_nxt = (cmd_group_mask == '0) ? S_DONE : S_WAIT_GRP;
            end
            S_WAIT_GRP: begin
                // busy on unselected groups is irrelevant
                if ((grp_busy & mask_q) == '0) state_nxt = S_READ;
            end
            S_READ: begin
                ram_rd_en = 1'b1;
                if (word_k == LAST_WORD) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // pipe empty means the last word is on wr_en this cycle
                if (vld_pipe == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                done           = 1'b1;
                err_empty_mask = (mask_q == '0);
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_lane
        awmf_wr_lane u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .load (vld_pipe[RD_LAT]),
            .sel  (mask_q[g]),
            .en   (wr_en[g])
        );
    end
endmodule
